// File: rtl/arrow_pkg.sv
// Shared definitions for the arrow pool mover.
//   COORD_W     : screen coordinate width
//   HIDE_COORD  : coordinate value reported by an idle slot
//   arrow_st_t  : per-slot state
//   cnt_width() : bit width needed to hold a down-counter starting at max_val
package arrow_pkg;

    localparam int unsigned          COORD_W    = 11;
    localparam logic [COORD_W-1:0]   HIDE_COORD = 11'h7FF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FLYING,
        ST_STUCK
    } arrow_st_t;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/arrow_slot.sv
// One arrow slot: state, coordinates and (sticky build only) stick counter.
// Ports:
//   clk, reset         : clock, async active-high reset
//   startOfFrame       : one-cycle frame pulse, advances the arrow
//   load               : take load_x/load_y and start flying (honoured in IDLE only)
//   crash              : retire the slot immediately
//   load_x, load_y     : launch position
//   pos_x, pos_y       : current position, HIDE_COORD while idle
//   active             : slot is not idle
// Build option: ARROW_STICKY_EN keeps an arrow at the top for STICK_FRAMES frames.
module arrow_slot
    import arrow_pkg::*;
#(
    parameter int unsigned ARROW_SPEED  = 10,
    parameter int unsigned TOP_LIMIT    = 0,
    parameter int unsigned STICK_FRAMES = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               load,
    input  logic               crash,
    input  logic [COORD_W-1:0] load_x,
    input  logic [COORD_W-1:0] load_y,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y,
    output logic               active
);

    localparam logic [COORD_W-1:0] SPEED_C    = COORD_W'(ARROW_SPEED);
    // Threshold compared at 32 bits so Y never wraps below zero.
    localparam int unsigned        TOP_THRESH = TOP_LIMIT + ARROW_SPEED;

    arrow_st_t state;
    logic      reach_top;

    assign reach_top = ({21'd0, pos_y} < TOP_THRESH);
    assign active    = (state != ST_IDLE);

`ifdef ARROW_STICKY_EN
    localparam int unsigned        STICK_W    = cnt_width(STICK_FRAMES);
    localparam logic [STICK_W-1:0] STICK_INIT = STICK_W'(STICK_FRAMES);
    localparam logic [COORD_W-1:0] TOP_Y      = COORD_W'(TOP_LIMIT);

    logic [STICK_W-1:0] stick_cnt;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            pos_x <= HIDE_COORD;
            pos_y <= HIDE_COORD;
`ifdef ARROW_STICKY_EN
            stick_cnt <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        state <= ST_FLYING;
                        pos_x <= load_x;
                        pos_y <= load_y;
                    end
                end
                ST_FLYING: begin
                    if (crash) begin
                        state <= ST_IDLE;
                        pos_x <= HIDE_COORD;
                        pos_y <= HIDE_COORD;
                    end else if (startOfFrame) begin
                        if (reach_top) begin
`ifdef ARROW_STICKY_EN
                            state     <= ST_STUCK;
                            pos_y     <= TOP_Y;
                            stick_cnt <= STICK_INIT;
`else
                            state <= ST_IDLE;
                            pos_x <= HIDE_COORD;
                            pos_y <= HIDE_COORD;
`endif
                        end else begin
                            pos_y <= pos_y - SPEED_C;
                        end
                    end
                end
`ifdef ARROW_STICKY_EN
                ST_STUCK: begin
                    // Counter was loaded on arrival; the frame that takes it
                    // to zero is the one that releases the slot.
                    if (crash || (startOfFrame && stick_cnt <= STICK_W'(1))) begin
                        state <= ST_IDLE;
                        pos_x <= HIDE_COORD;
                        pos_y <= HIDE_COORD;
                    end else if (startOfFrame) begin
                        stick_cnt <= stick_cnt - STICK_W'(1);
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                    pos_x <= HIDE_COORD;
                    pos_y <= HIDE_COORD;
                end
            endcase
        end
    end

endmodule

// File: rtl/arrow_pool_move.sv
// Pool of NUM_ARROWS arrow slots fired from the character position.
// A fire-key rising edge loads the lowest-index idle slot when the frame
// cooldown has expired; arrows climb ARROW_SPEED pixels per frame.
// Ports:
//   clk, reset          : clock, async active-high reset
//   startOfFrame        : one-cycle frame pulse
//   spacePress          : fire key level (edge detected here)
//   charTopX, charTopY  : character position, launch point
//   crash[i]            : retire slot i
//   topLeftX/Y[i]       : slot i position, 11'h7FF when idle
//   active[i]           : slot i in flight (or stuck)
//   shotFired           : one-cycle pulse per accepted shot
// Build option: ARROW_STICKY_EN (arrows stick at the top for STICK_FRAMES).
module arrow_pool_move
    import arrow_pkg::*;
#(
    parameter int unsigned NUM_ARROWS      = 2,
    parameter int unsigned ARROW_SPEED     = 10,
    parameter int unsigned TOP_LIMIT       = 0,
    parameter int unsigned COOLDOWN_FRAMES = 4,
    parameter int unsigned STICK_FRAMES    = 15
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               startOfFrame,
    input  logic                               spacePress,
    input  logic [COORD_W-1:0]                 charTopX,
    input  logic [COORD_W-1:0]                 charTopY,
    input  logic [NUM_ARROWS-1:0]              crash,
    output logic [NUM_ARROWS-1:0][COORD_W-1:0] topLeftX,
    output logic [NUM_ARROWS-1:0][COORD_W-1:0] topLeftY,
    output logic [NUM_ARROWS-1:0]              active,
    output logic                               shotFired
);

    localparam int unsigned     CD_W    = cnt_width(COOLDOWN_FRAMES);
    localparam logic [CD_W-1:0] CD_INIT = CD_W'(COOLDOWN_FRAMES);

    logic                  spacePress_q;
    logic [CD_W-1:0]       cooldown;
    logic                  fire_req;
    logic                  accept;
    logic [NUM_ARROWS-1:0] idle;
    logic [NUM_ARROWS-1:0] sel;
    logic [NUM_ARROWS-1:0] load;

    assign fire_req = spacePress & ~spacePress_q;
    // Eligibility comes from registered state, so a slot retiring this
    // cycle is still busy and cannot be picked.
    assign idle     = ~active;
    assign accept   = fire_req && (cooldown == '0) && (|idle);
    assign load     = accept ? sel : '0;

    // Lowest-index idle slot, one-hot.
    always_comb begin
        logic taken;
        sel   = '0;
        taken = 1'b0;
        for (int unsigned i = 0; i < NUM_ARROWS; i++) begin
            if (idle[i] && !taken) begin
                sel[i] = 1'b1;
                taken  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spacePress_q <= 1'b0;
            cooldown     <= '0;
            shotFired    <= 1'b0;
        end else begin
            spacePress_q <= spacePress;
            shotFired    <= accept;
            if (accept)
                cooldown <= CD_INIT;
            else if (startOfFrame && cooldown != '0)
                cooldown <= cooldown - CD_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_ARROWS; g++) begin : g_slot
        arrow_slot #(
            .ARROW_SPEED  (ARROW_SPEED),
            .TOP_LIMIT    (TOP_LIMIT),
            .STICK_FRAMES (STICK_FRAMES)
        ) u_slot (
            .clk          (clk),
            .reset        (reset),
            .startOfFrame (startOfFrame),
            .load         (load[g]),
            .crash        (crash[g]),
            .load_x       (charTopX),
            .load_y       (charTopY),
            .pos_x        (topLeftX[g]),
            .pos_y        (topLeftY[g]),
            .active       (active[g])
        );
    end

endmodule
